rom_loader: RTL and testbench

//  Boot sequencer that copies the combinational boot ROM image into main RAM, one byte per write.
//  It drives the ROM address and samples the ROM's byte and last-byte (done) flag.
//  It issues req/ack byte writes to RAM and holds the CPU in reset until the copy succeeds.

---
 rtl/rom_loader_pkg.sv | 4 +
 rtl/rom_loader_if.sv | 20 ++
 rtl/rom_loader_ack_watchdog.sv | 19 +
 rtl/rom_loader.sv | 107 ++++++++++
 tb/tb_rom_loader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared state encoding for the boot ROM loader and its bench
package rom_loader_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, WRITE = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_e;
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: ROM read bus plus RAM byte-write req/ack bus
//   master (loader): drives rom_address, ram_address, ram_data, ram_write_request
//   slave (memories): drives rom_byte, rom_done, ram_write_ack
interface rom_loader_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [7:0]            rom_byte;
  logic                  rom_done;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_data;
  logic                  ram_write_request;
  logic                  ram_write_ack;
  modport master (
    output rom_address, ram_address, ram_data, ram_write_request,
    input  rom_byte, rom_done, ram_write_ack
  );
  modport slave (
    input  rom_address, ram_address, ram_data, ram_write_request,
    output rom_byte, rom_done, ram_write_ack
  );
endinterface

// File: rtl/rom_loader_ack_watchdog.sv
// ack_watchdog: counts unacknowledged write cycles and flags the limit-th one
//   clk, reset (async, active-high), clear, enable, limit[7:0] -> expired
//   limit = 0 disables expiry.
module ack_watchdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);
  logic [7:0] cnt_q, cnt_d;
  // Fires during the limit-th waiting cycle so the request is held exactly limit cycles.
  assign expired = enable && limit != 8'd0 && cnt_q == limit - 8'd1;
  always_comb cnt_d = clear ? 8'd0 : (enable && !expired) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rom_loader.sv
// rom_loader: copies the boot ROM image into RAM byte by byte, holding the CPU in reset until done
//   clk, reset (async, active-high), start (reload pulse, honoured in DONE/ERROR)
//   bus (rom_loader_if.master): ROM address/data/done and RAM req/ack write port
//   cpu_reset, load_complete, load_error, byte_count
//   checksum[7:0] present only when ROM_LOADER_CHECKSUM_EN is defined
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_BASE    = 0,
  parameter int MAX_BYTES   = 4096,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  rom_loader_if.master          bus,
  output logic                  cpu_reset,
  output logic                  load_complete,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] byte_count
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]            checksum
`endif
);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(RAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_BYTES - 1);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d, cnt_q, cnt_d;
  logic [7:0]            data_q, data_d;
  logic                  last_q, last_d, cpu_reset_q, cpu_reset_d, expired, ack, restart;
  assign ack     = state_q == WRITE && bus.ram_write_ack;
  assign restart = (state_q == DONE || state_q == ERROR) && start;
  ack_watchdog u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == FETCH),
    .enable  (state_q == WRITE && !bus.ram_write_ack),
    .limit   (8'(ACK_TIMEOUT)),
    .expired (expired)
  );
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cpu_reset_d = 1'b1;
    case (state_q)
      FETCH: begin
        data_d  = bus.rom_byte;
        last_d  = bus.rom_done;
        addr_d  = BASE + idx_q;
        state_d = WRITE;
      end
      WRITE:
        if (ack) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last_q ? DONE : idx_q == LAST_IDX ? ERROR : FETCH;
          idx_d   = (last_q || idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
        end else if (expired) state_d = ERROR;
      DONE: cpu_reset_d = start;
      default: ;
    endcase
    if (restart) begin
      state_d = FETCH;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= FETCH;
      idx_q       <= '0;
      addr_q      <= BASE;
      data_q      <= 8'd0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  always_comb sum_d = restart ? 8'd0 : ack ? sum_q + data_q : sum_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sum_q <= 8'd0;
    else sum_q <= sum_d;
  assign checksum = sum_q;
`endif
  assign bus.rom_address       = idx_q;
  assign bus.ram_address       = addr_q;
  assign bus.ram_data          = data_q;
  assign bus.ram_write_request = state_q == WRITE;
  assign cpu_reset             = cpu_reset_q;
  assign load_complete         = state_q == DONE;
  assign load_error            = state_q == ERROR;
  assign byte_count            = cnt_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed self-checking bench for rom_loader (default and small-limit instances)
module tb_rom_loader;
  logic clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  rom_loader_if #(.ADDR_WIDTH(32)) a_if ();
  rom_loader_if #(.ADDR_WIDTH(32)) b_if ();
  logic a_cr, a_lc, a_le, b_cr, b_lc, b_le;
  logic [31:0] a_bc, b_bc;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] a_cs, b_cs;
`endif
  rom_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(a_if),
    .cpu_reset(a_cr), .load_complete(a_lc), .load_error(a_le), .byte_count(a_bc)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(a_cs)
`endif
  );
  rom_loader #(.MAX_BYTES(16), .ACK_TIMEOUT(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(b_if),
    .cpu_reset(b_cr), .load_complete(b_lc), .load_error(b_le), .byte_count(b_bc)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(b_cs)
`endif
  );
  int a_mode = 0, a_exprun = 1;
  bit a_tbl = 1'b0, b_ack_on = 1'b0;
  logic [7:0] tbl [4] = '{8'd15, 8'd14, 8'd1, 8'd255};
  function automatic logic [7:0] rom_a(input logic [31:0] i);
    return 8'(i * 7 + 3);
  endfunction
  function automatic logic [7:0] rom_b(input logic [31:0] i);
    return i[7:0] ^ 8'h5A;
  endfunction
  int a_run, a_wr, a_stab, a_badrun, b_wr, b_hi;
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [16];
  logic [31:0] a_pa, a_pr;
  logic [7:0] a_pd;
  assign a_if.rom_byte = a_tbl ? (a_if.rom_address < 32'd4 ? tbl[a_if.rom_address[1:0]] : 8'd0)
                               : rom_a(a_if.rom_address);
  assign a_if.rom_done = a_if.rom_address == (a_tbl ? 32'd3 : 32'd49);
  assign a_if.ram_write_ack = a_mode == 0 ? 1'b1 : (a_if.ram_write_request && a_run == 3);
  assign b_if.rom_byte = rom_b(b_if.rom_address);
  assign b_if.rom_done = 1'b0;
  assign b_if.ram_write_ack = b_ack_on;
  always @(posedge clk or posedge reset)
    if (reset) begin
      a_run <= 0; a_wr <= 0; a_stab <= 0; a_badrun <= 0;
      for (int k = 0; k < 64; k++) mem_a[k] <= 8'd0;
    end else if (a_if.ram_write_request) begin
      if (a_run > 0 && (a_if.ram_address != a_pa || a_if.ram_data != a_pd || a_if.rom_address != a_pr))
        a_stab <= a_stab + 1;
      a_pa <= a_if.ram_address; a_pd <= a_if.ram_data; a_pr <= a_if.rom_address;
      if (a_if.ram_write_ack) begin
        mem_a[a_if.ram_address[5:0]] <= a_if.ram_data;
        a_wr <= a_wr + 1;
        a_run <= 0;
        if (a_run + 1 != a_exprun) a_badrun <= a_badrun + 1;
      end else a_run <= a_run + 1;
    end
  always @(posedge clk or posedge reset)
    if (reset) begin
      b_wr <= 0; b_hi <= 0;
      for (int k = 0; k < 16; k++) mem_b[k] <= 8'd0;
    end else if (b_if.ram_write_request) begin
      b_hi <= b_hi + 1;
      if (b_if.ram_write_ack) begin
        mem_b[b_if.ram_address[3:0]] <= b_if.ram_data;
        b_wr <= b_wr + 1;
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask
  function automatic int mism_a(input int len);
    int m = 0;
    for (int i = 0; i < len; i++)
      if (mem_a[i] !== (a_tbl ? tbl[i[1:0]] : rom_a(i))) m++;
    return m;
  endfunction
  initial begin
    int n, m;
    logic [7:0] s;
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", a_if.rom_address, 0);
    chk("rst_ram_addr", a_if.ram_address, 0);
    chk("rst_ram_data", a_if.ram_data, 0);
    chk("rst_req", a_if.ram_write_request, 0);
    chk("rst_cpu_reset", a_cr, 1);
    chk("rst_complete", a_lc, 0);
    chk("rst_error", a_le, 0);
    chk("rst_count", a_bc, 0);
    // 1: 50 bytes, ack tied high -> 2 cycles per byte
    reset = 1'b0;
    for (n = 1; n <= 200; n++) begin @(negedge clk); if (a_lc) break; end
    chk("t1_done_cycle", n, 100);
    chk("t1_cpu_reset_on_entry", a_cr, 1);
    @(negedge clk);
    chk("t1_cpu_reset_low", a_cr, 0);
    chk("t1_count", a_bc, 50);
    chk("t1_writes", a_wr, 50);
    chk("t1_image", mism_a(50), 0);
    chk("t1_req_len", a_badrun, 0);
    // 2: ack after 3 wait cycles -> request high 4 cycles, 5 cycles per byte
    a_mode = 1; a_exprun = 4;
    pulse_reset();
    for (n = 1; n <= 400; n++) begin @(negedge clk); if (a_lc) break; end
    chk("t2_done_cycle", n, 250);
    chk("t2_stable", a_stab, 0);
    chk("t2_req_len", a_badrun, 0);
    chk("t2_writes", a_wr, 50);
    chk("t2_image", mism_a(50), 0);
    chk("t2_count", a_bc, 50);
    // 5: reset during WRITE of byte 20
    pulse_reset();
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (a_if.ram_write_request && a_if.rom_address == 32'd20) break;
    end
    chk("t5_count_before", a_bc, 20);
    reset = 1'b1;
    #1;
    chk("t5_rom_addr", a_if.rom_address, 0);
    chk("t5_ram_addr", a_if.ram_address, 0);
    chk("t5_req", a_if.ram_write_request, 0);
    chk("t5_cpu_reset", a_cr, 1);
    chk("t5_count", a_bc, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("t5_restart_req", a_if.ram_write_request, 1);
    chk("t5_restart_addr", a_if.ram_address, 0);
    chk("t5_restart_data", a_if.ram_data, rom_a(0));
    for (n = 1; n <= 400; n++) begin @(negedge clk); if (a_lc) break; end
    chk("t5_done", a_lc, 1);
    chk("t5_count_final", a_bc, 50);
    chk("t5_image", mism_a(50), 0);
    // 6: 4-byte table image, start ignored in WRITE, start in DONE reloads
    a_tbl = 1'b1;
    pulse_reset();
    for (n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (a_if.ram_write_request && a_if.rom_address == 32'd1) break;
    end
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("t6_start_in_write_req", a_if.ram_write_request, 1);
    chk("t6_start_in_write_addr", a_if.rom_address, 1);
    chk("t6_start_in_write_count", a_bc, 1);
    for (n = 1; n <= 100; n++) begin @(negedge clk); if (a_lc) break; end
    chk("t6_done", a_lc, 1);
    chk("t6_count", a_bc, 4);
    chk("t6_image", mism_a(4), 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("t6_checksum", a_cs, 8'h1D);
`endif
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("t6_reload_complete", a_lc, 0);
    chk("t6_reload_cpu_reset", a_cr, 1);
    chk("t6_reload_count", a_bc, 0);
    chk("t6_reload_addr", a_if.rom_address, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("t6_reload_checksum", a_cs, 0);
`endif
    for (n = 1; n <= 100; n++) begin @(negedge clk); if (a_lc) break; end
    chk("t6_redone_count", a_bc, 4);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("t6_redone_checksum", a_cs, 8'h1D);
`endif
    // 3: ack never arrives, timeout 10
    b_ack_on = 1'b0;
    pulse_reset();
    for (n = 1; n <= 50; n++) begin @(negedge clk); if (b_le) break; end
    chk("t3_error_cycle", n, 11);
    chk("t3_req_cycles", b_hi, 10);
    chk("t3_req_low", b_if.ram_write_request, 0);
    chk("t3_cpu_reset", b_cr, 1);
    repeat (3) @(negedge clk);
    chk("t3_error_held", b_le, 1);
    chk("t3_count_frozen", b_bc, 0);
    b_ack_on = 1'b1;
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    chk("t3_restart_error", b_le, 0);
    chk("t3_restart_rom_addr", b_if.rom_address, 0);
    @(negedge clk);
    chk("t3_restart_req", b_if.ram_write_request, 1);
    chk("t3_restart_ram_addr", b_if.ram_address, 0);
    // 4: no rom_done, MAX_BYTES 16
    for (n = 1; n <= 100; n++) begin @(negedge clk); if (b_le) break; end
    chk("t4_error", b_le, 1);
    chk("t4_count", b_bc, 16);
    chk("t4_writes", b_wr, 16);
    m = 0;
    s = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if (mem_b[i] !== rom_b(i)) m++;
      s = s + rom_b(i);
    end
    chk("t4_image", m, 0);
    chk("t4_rom_addr", b_if.rom_address, 15);
    chk("t4_cpu_reset", b_cr, 1);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("t4_checksum", b_cs, s);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
